// File: rtl/mem_bus_arbiter_if.sv
// One requester channel of mem_bus_arbiter (instantiate once for the CPU, once for the DMA/loader).
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input  gnt, done, rdata);
  modport slave  (input  req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter and cycle sequencer for the CPUCR main memory port (LE-strobed, shared data bus).
// Define MEM_WRITE_VERIFY_EN to read back every write and flag mismatches on verify_err_o.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int WR_PULSE = 2,
  parameter int FAIR     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.slave  cpu_s,
  mem_bus_arbiter_if.slave  dma_s,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_le_o,
  inout  wire  [DATA_W-1:0] mem_data_io,
  output logic              verify_err_o
);
  localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_CAP, WR_STROBE, WR_REL
`ifdef MEM_WRITE_VERIFY_EN
    , VF_ADDR, VF_CAP
`endif
  } state_t;

  state_t            state_q;
  logic              owner_q;   // 0 = CPU, 1 = DMA
  logic              last_q;    // requester served last
  logic              cpu_gnt_q, dma_gnt_q;
  logic              cpu_done_q, dma_done_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              le_q, drv_q;
  logic [CNT_W-1:0]  cnt_q;
`ifdef MEM_WRITE_VERIFY_EN
  logic              verr_q;
`endif

  logic              cpu_win_d, dma_win_d, sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  // CPU wins unless round-robin says the DMA is owed the slot.
  always_comb begin
    cpu_win_d   = cpu_s.req && (!dma_s.req || (FAIR == 0) || last_q);
    dma_win_d   = dma_s.req && !cpu_win_d;
    sel_we_d    = dma_win_d ? dma_s.we    : cpu_s.we;
    sel_addr_d  = dma_win_d ? dma_s.addr  : cpu_s.addr;
    sel_wdata_d = dma_win_d ? dma_s.wdata : cpu_s.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      le_q        <= 1'b1;
      drv_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef MEM_WRITE_VERIFY_EN
      verr_q      <= 1'b0;
`endif
    end else begin
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cpu_gnt_q <= cpu_win_d;
          dma_gnt_q <= dma_win_d;
          if (cpu_win_d || dma_win_d) begin
            owner_q <= dma_win_d;
            last_q  <= dma_win_d;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
            if (sel_we_d) begin
              le_q    <= 1'b0;
              drv_q   <= 1'b1;
              cnt_q   <= CNT_W'(WR_PULSE - 1);
              state_q <= WR_STROBE;
            end else begin
              state_q <= RD_ADDR;
            end
          end
        end
        RD_ADDR: state_q <= RD_CAP;
        RD_CAP: begin
          if (owner_q) begin
            dma_rdata_q <= mem_data_io;
            dma_done_q  <= 1'b1;
          end else begin
            cpu_rdata_q <= mem_data_io;
            cpu_done_q  <= 1'b1;
          end
          state_q <= IDLE;
        end
        WR_STROBE: begin
          if (cnt_q == '0) begin
            le_q    <= 1'b1;
            drv_q   <= 1'b0;
            state_q <= WR_REL;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WR_REL: begin
`ifdef MEM_WRITE_VERIFY_EN
          state_q <= VF_ADDR;
`else
          if (owner_q) dma_done_q <= 1'b1;
          else         cpu_done_q <= 1'b1;
          state_q <= IDLE;
`endif
        end
`ifdef MEM_WRITE_VERIFY_EN
        VF_ADDR: state_q <= VF_CAP;
        VF_CAP: begin
          if (mem_data_io != wdata_q) verr_q <= 1'b1;
          if (owner_q) dma_done_q <= 1'b1;
          else         cpu_done_q <= 1'b1;
          state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_s.gnt   = cpu_gnt_q;
  assign cpu_s.done  = cpu_done_q;
  assign cpu_s.rdata = cpu_rdata_q;
  assign dma_s.gnt   = dma_gnt_q;
  assign dma_s.done  = dma_done_q;
  assign dma_s.rdata = dma_rdata_q;

  assign mem_addr_o  = addr_q;
  assign mem_le_o    = le_q;
  // The memory owns the bus whenever LE is high.
  assign mem_data_io = drv_q ? wdata_q : {DATA_W{1'bz}};

`ifdef MEM_WRITE_VERIFY_EN
  assign verify_err_o = verr_q;
`else
  assign verify_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requester drivers push expectations, a monitor pops them on done.
module tb_mem_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int WP = 2;
  localparam int FAIR = 1;
`ifdef MEM_WRITE_VERIFY_EN
  localparam int WLAT = WP + 3;
`else
  localparam int WLAT = WP + 1;
`endif

  typedef struct {
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dma_if ();

  logic [AW-1:0] mem_addr;
  logic          mem_le;
  wire  [DW-1:0] mem_data;
  logic          verify_err;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_PULSE(WP), .FAIR(FAIR)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_s(cpu_if), .dma_s(dma_if),
    .mem_addr_o(mem_addr), .mem_le_o(mem_le), .mem_data_io(mem_data),
    .verify_err_o(verify_err)
  );

  // Memory device: drives the bus while LE is high, captures while LE is low.
  logic [DW-1:0] mem_arr [0:65535];
  logic          corrupt = 1'b0;
  logic [DW-1:0] mem_rd;
  assign mem_rd   = corrupt ? '0 : mem_arr[mem_addr];
  assign mem_data = mem_le ? mem_rd : {DW{1'bz}};
  always @(negedge clk) if (!mem_le) mem_arr[mem_addr] <= mem_data;

  logic [DW-1:0] ref_mem [0:65535];
  exp_t q_cpu[$];
  exp_t q_dma[$];
  bit   grant_log[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endfunction

  task automatic drive(input bit d, input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (d) begin dma_if.req = r; dma_if.we = we; dma_if.addr = a; dma_if.wdata = wd; end
    else   begin cpu_if.req = r; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = wd; end
  endtask

  // Called at posedge+1; returns at posedge+1 of the done cycle.
  task automatic issue(input bit d, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit keep);
    exp_t e;
    bit ok;
    e.we = we; e.addr = a; e.wdata = wd;
    e.rdata = we ? '0 : ref_mem[a];
    if (we) ref_mem[a] = wd;
    if (d) q_dma.push_back(e); else q_cpu.push_back(e);
    drive(d, 1'b1, we, a, wd);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      ok = d ? dma_if.done : cpu_if.done;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout req=%0d addr=%0h got=no_done want=done", d, a);
    end
    if (!keep) drive(d, 1'b0, we, a, wd);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: grant tracking, latency, read data, bus ownership and strobe width.
  initial begin
    bit [1:0] g, gp, dp, dn;
    int st [2];
    int cyc;
    int lowcnt;
    exp_t e;
    string nm;
    logic [DW-1:0] rd;
    gp = '0; dp = '0; cyc = 0; lowcnt = 0;
    st[0] = 0; st[1] = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        gp = '0; dp = '0; lowcnt = 0;
        continue;
      end
      g  = {dma_if.gnt, cpu_if.gnt};
      dn = {dma_if.done, cpu_if.done};
      chk("gnt_exclusive", {31'b0, g[0] & g[1]}, 0);
      if (mem_le) begin
        chk("bus_idle_value", {24'b0, mem_data}, {24'b0, mem_rd});
        if (lowcnt > 0) chk("le_low_width", lowcnt, WP);
        lowcnt = 0;
      end else begin
        lowcnt++;
        chk("wr_data", {24'b0, mem_data}, {24'b0, g[1] ? dma_if.wdata : cpu_if.wdata});
        chk("wr_addr", {16'b0, mem_addr}, {16'b0, g[1] ? dma_if.addr : cpu_if.addr});
      end
      for (int d = 0; d < 2; d++) begin
        nm = d ? "dma" : "cpu";
        if (g[d] && (!gp[d] || dp[d])) begin
          st[d] = cyc;
          grant_log.push_back(d[0]);
        end
        if (dn[d]) begin
          if ((d ? q_dma.size() : q_cpu.size()) == 0) begin
            checks++; errors++;
            $display("FAIL %s_unexpected_done got=done want=none", nm);
          end else begin
            e  = d ? q_dma.pop_front() : q_cpu.pop_front();
            rd = d ? dma_if.rdata : cpu_if.rdata;
            chk({nm, "_latency"}, cyc - st[d], e.we ? WLAT : 2);
            if (!e.we) chk({nm, "_rdata"}, {24'b0, rd}, {24'b0, e.rdata});
          end
        end
      end
      gp = g;
      dp = dn;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bit exp_log[$];
    int cpn, dmn;
    bit last;
    bit ok;
    rst_n = 1'b0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (2) @(posedge clk); #1;
    chk("rst_le", {31'b0, mem_le}, 1);
    chk("rst_addr", {16'b0, mem_addr}, 0);
    chk("rst_gnt", {30'b0, dma_if.gnt, cpu_if.gnt}, 0);
    chk("rst_done", {30'b0, dma_if.done, cpu_if.done}, 0);
    chk("rst_rdata", {16'b0, dma_if.rdata, cpu_if.rdata}, 0);
    chk("rst_verify_err", {31'b0, verify_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 1, 16'h0010, 8'h3C, 0);
    issue(0, 0, 16'h0010, 8'h00, 0);

    // Both requesters raised together, each holding req for four transactions.
    do_reset();
    grant_log.delete();
    fork
      begin for (int i = 0; i < 4; i++) issue(0, 1, AW'(16'h0100 + i), DW'($urandom), i < 3); end
      begin for (int i = 0; i < 4; i++) issue(1, 1, AW'(16'h0200 + i), DW'($urandom), i < 3); end
    join
    cpn = 4; dmn = 4; last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (cpn > 0 && (dmn == 0 || FAIR == 0 || last)) begin exp_log.push_back(1'b0); cpn--; last = 1'b0; end
      else begin exp_log.push_back(1'b1); dmn--; last = 1'b1; end
    end
    chk("arb_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("arb_order", {31'b0, grant_log[i]}, {31'b0, exp_log[i]});

    // Loader fills 0..15, CPU reads them back.
    for (int i = 0; i < 16; i++) issue(1, 1, AW'(i), DW'(i), (i < 15) && $urandom_range(0, 1) == 1);
    for (int i = 0; i < 16; i++) issue(0, 0, AW'(i), '0, (i < 15) && $urandom_range(0, 1) == 1);

    // Random concurrent traffic on disjoint regions.
    fork
      begin
        for (int i = 0; i < 16; i++) issue(0, 1, AW'(16'h1000 + i), DW'($urandom), 0);
        for (int i = 0; i < 25; i++) begin
          bit k;
          k = (i < 24) && $urandom_range(0, 2) == 0;
          issue(0, $urandom_range(0, 1) == 1, AW'(16'h1000 + $urandom_range(0, 15)), DW'($urandom), k);
          if (!k) begin repeat ($urandom_range(0, 3)) @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 16; i++) issue(1, 1, AW'(16'h2000 + i), DW'($urandom), 0);
        for (int i = 0; i < 25; i++) begin
          bit k;
          k = (i < 24) && $urandom_range(0, 2) == 0;
          issue(1, $urandom_range(0, 1) == 1, AW'(16'h2000 + $urandom_range(0, 15)), DW'($urandom), k);
          if (!k) begin repeat ($urandom_range(0, 3)) @(posedge clk); #1; end
        end
      end
    join

    // Reset in the middle of the write strobe: data already committed, no done.
    drive(0, 1, 1, 16'h0030, 8'h77);
    ref_mem[16'h0030] = 8'h77;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #1; ok = !mem_le; end
    chk("rmw_le_low", {31'b0, mem_le}, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("rmw_le_release", {31'b0, mem_le}, 1);
    chk("rmw_bus_release", {24'b0, mem_data}, {24'b0, mem_rd});
    chk("rmw_no_done", {30'b0, dma_if.done, cpu_if.done}, 0);
    drive(0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rmw_idle_done", {30'b0, dma_if.done, cpu_if.done}, 0);
      chk("rmw_idle_gnt", {30'b0, dma_if.gnt, cpu_if.gnt}, 0);
    end
    issue(0, 0, 16'h0030, '0, 0);

`ifdef MEM_WRITE_VERIFY_EN
    issue(0, 1, 16'h0040, 8'hA5, 0);
    chk("verify_ok", {31'b0, verify_err}, 0);
    corrupt = 1'b1;
    issue(0, 1, 16'h0041, 8'h5A, 0);
    corrupt = 1'b0;
    chk("verify_flag", {31'b0, verify_err}, 1);
    issue(1, 1, 16'h0042, 8'h11, 0);
    chk("verify_sticky", {31'b0, verify_err}, 1);
`else
    chk("verify_tied", {31'b0, verify_err}, 0);
`endif

    repeat (3) @(posedge clk); #1;
    chk("queues_drained", q_cpu.size() + q_dma.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
